// File: rtl/cordic_atan2_phase_if.sv
// cordic_atan2_phase_if
//   Handshake bundle for the CORDIC atan2 phase engine.
//   Input side : in_valid/in_ready with signed x_in, y_in (DATA_W bits).
//   Output side: out_valid/out_ready with signed phase_out (8 bits,
//                LSB = pi/128 rad) and, when CORDIC_MAG_OUT_EN is defined,
//                unsigned mag_out (DATA_W+2 bits, un-normalised CORDIC x).
//   modport slave  : the engine side.
//   modport master : the upstream/downstream side (testbench or datapath).
interface cordic_atan2_phase_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [7:0]        phase_out;
`ifdef CORDIC_MAG_OUT_EN
    logic [DATA_W+1:0]        mag_out;

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, phase_out, mag_out
    );
    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, phase_out, mag_out
    );
`else
    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, phase_out
    );
    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, phase_out
    );
`endif
endinterface

// File: rtl/cordic_atan2_phase.sv
// cordic_atan2_phase
//   Iterative CORDIC vectoring engine producing the signed phase
//   atan2(y, x) of a DATA_W-bit vector (used as the 2*theta phase of the
//   Jacobi rotation, y = 2*a_pq, x = a_qq - a_pp).
//   One micro-rotation per clock; ITERATIONS (1..10) rotations per vector.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : cordic_atan2_phase_if.slave
//          in_valid/in_ready/x_in/y_in   -> vector acceptance (IDLE only)
//          out_valid/out_ready/phase_out -> result, held until taken
//          mag_out (CORDIC_MAG_OUT_EN)   -> final x register, gain ~1.647
//
// Optional feature macro: CORDIC_MAG_OUT_EN (adds the mag_out register).
module cordic_atan2_phase #(
    parameter int DATA_W     = 8,
    parameter int ITERATIONS = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    cordic_atan2_phase_if.slave         bus
);
    // Two guard bits: pre-rotation can negate -2^(DATA_W-1) and the CORDIC
    // gain grows |v| by ~1.65, so DATA_W+2 holds every intermediate x/y.
    localparam int W  = DATA_W + 2;
    localparam int ZW = 13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic signed [W-1:0]   r_x;
    logic signed [W-1:0]   r_y;
    logic signed [ZW-1:0]  r_z;
    logic                  r_zero;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic signed [7:0]     r_phase;
`ifdef CORDIC_MAG_OUT_EN
    logic [W-1:0]          r_mag;
`endif

    // atan(2^-i) in units of pi/2048
    function automatic logic signed [ZW-1:0] atan_rom(input logic [3:0] i);
        case (i)
            4'd0:    atan_rom = 13'sd512;
            4'd1:    atan_rom = 13'sd302;
            4'd2:    atan_rom = 13'sd160;
            4'd3:    atan_rom = 13'sd81;
            4'd4:    atan_rom = 13'sd41;
            4'd5:    atan_rom = 13'sd20;
            4'd6:    atan_rom = 13'sd10;
            4'd7:    atan_rom = 13'sd5;
            4'd8:    atan_rom = 13'sd3;
            4'd9:    atan_rom = 13'sd1;
            default: atan_rom = 13'sd0;
        endcase
    endfunction

    // ---------------- capture / pre-rotation ----------------
    logic signed [W-1:0]  w_x_ext, w_y_ext;
    logic signed [W-1:0]  w_px, w_py;
    logic signed [ZW-1:0] w_pz;
    logic                 w_zero_in;

    assign w_x_ext   = {{(W-DATA_W){bus.x_in[DATA_W-1]}}, bus.x_in};
    assign w_y_ext   = {{(W-DATA_W){bus.y_in[DATA_W-1]}}, bus.y_in};
    assign w_zero_in = (bus.x_in == '0) && (bus.y_in == '0);

    // Fold the left half-plane onto the right one with an exact +-90 deg
    // turn so the micro-rotations (total reach ~+-99.9 deg) always converge.
    always_comb begin
        w_px = w_x_ext;
        w_py = w_y_ext;
        w_pz = '0;
        if (w_x_ext[W-1]) begin
            if (!w_y_ext[W-1]) begin
                w_px = w_y_ext;
                w_py = -w_x_ext;
                w_pz = 13'sd1024;
            end else begin
                w_px = -w_y_ext;
                w_py = w_x_ext;
                w_pz = -13'sd1024;
            end
        end
    end

    // ---------------- one micro-rotation ----------------
    logic signed [W-1:0]  w_xs, w_ys;
    logic signed [W-1:0]  w_x_nx, w_y_nx;
    logic signed [ZW-1:0] w_z_nx;
    logic signed [ZW-1:0] w_atan;

    assign w_xs   = r_x >>> r_cnt;
    assign w_ys   = r_y >>> r_cnt;
    assign w_atan = atan_rom(r_cnt);

    // Drive y toward zero; both updates read the pre-update x and y.
    always_comb begin
        if (!r_y[W-1]) begin
            w_x_nx = r_x + w_ys;
            w_y_nx = r_y - w_xs;
            w_z_nx = r_z + w_atan;
        end else begin
            w_x_nx = r_x - w_ys;
            w_y_nx = r_y + w_xs;
            w_z_nx = r_z - w_atan;
        end
    end

    // ---------------- output rounding ----------------
    // z LSB is pi/2048, phase LSB is pi/128: round-half-up by 16, then clamp
    // so +pi (128) lands on 127.
    logic signed [ZW-1:0] w_z_rnd, w_z_q;
    logic signed [7:0]    w_phase_sat;

    assign w_z_rnd = w_z_nx + 13'sd8;
    assign w_z_q   = w_z_rnd >>> 4;

    always_comb begin
        if (w_z_q > 13'sd127)
            w_phase_sat = 8'sd127;
        else if (w_z_q < -13'sd128)
            w_phase_sat = -8'sd128;
        else
            w_phase_sat = w_z_q[7:0];
    end

    wire w_last = (r_cnt == 4'(ITERATIONS - 1));

    // ---------------- control + datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_phase     <= '0;
`ifdef CORDIC_MAG_OUT_EN
            r_mag       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x        <= w_px;
                        r_y        <= w_py;
                        r_z        <= w_pz;
                        r_zero     <= w_zero_in;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_x   <= w_x_nx;
                    r_y   <= w_y_nx;
                    r_z   <= w_z_nx;
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_phase     <= r_zero ? 8'sd0 : w_phase_sat;
`ifdef CORDIC_MAG_OUT_EN
                        r_mag       <= r_zero ? '0 : w_x_nx;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.phase_out = r_phase;
`ifdef CORDIC_MAG_OUT_EN
    assign bus.mag_out   = r_mag;
`endif

endmodule

// File: tb/tb_cordic_atan2_phase.sv
module tb_cordic_atan2_phase;
    localparam int DATA_W = 8;
    localparam int ITER   = 10;
    localparam real PI    = 3.14159265358979323846;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cordic_atan2_phase_if #(.DATA_W(DATA_W)) bus ();

    cordic_atan2_phase #(.DATA_W(DATA_W), .ITERATIONS(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the spec's vectoring recipe in plain integer arithmetic.
    function automatic void model(input int xi, input int yi, output int ph, output int mg);
        int atan_tab [10] = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1};
        int x, y, z, xs, ys, q;
        if (xi == 0 && yi == 0) begin
            ph = 0;
            mg = 0;
            return;
        end
        if (xi >= 0)      begin x = xi;  y = yi;  z = 0;     end
        else if (yi >= 0) begin x = yi;  y = -xi; z = 1024;  end
        else              begin x = -yi; y = xi;  z = -1024; end
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (y >= 0) begin x = x + ys; y = y - xs; z = z + atan_tab[i]; end
            else        begin x = x - ys; y = y + xs; z = z - atan_tab[i]; end
        end
        q  = (z + 8) >>> 4;
        ph = (q > 127) ? 127 : (q < -128) ? -128 : q;
        mg = x;
    endfunction

    // Ideal phase in pi/128 units, clamped to the output range.
    function automatic int ideal_phase(input int xi, input int yi);
        real a;
        int  p;
        a = $atan2(real'(yi), real'(xi)) * 128.0 / PI;
        p = (a >= 0.0) ? int'(a + 0.5) : -int'(-a + 0.5);
        if (p > 127)  p = 127;
        if (p < -128) p = -128;
        return p;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rd_mag();
`ifdef CORDIC_MAG_OUT_EN
        return int'(bus.mag_out);
`else
        return 0;
`endif
    endfunction

    // Drives one vector, waits (bounded) for the result, takes it.
    task automatic run_vec(input int xv, input int yv, output int ph, output int mg,
                           output int lat, output bit ok);
        int t;
        ok = 1'b1;
        t  = 0;
        while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
        bus.x_in     = DATA_W'(xv);
        bus.y_in     = DATA_W'(yv);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!bus.out_valid) ok = 1'b0;
        ph = int'(bus.phase_out);
        mg = rd_mag();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.phase_out !== 8'sd0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b phase=%0d, required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.phase_out);
        end
`ifdef CORDIC_MAG_OUT_EN
        checks++;
        if (bus.mag_out !== '0) begin
            failures++;
            $display("FAIL reset_mag: mag=%0d required 0", bus.mag_out);
        end
`endif
    endtask

    task automatic test_axes();
        int xs [6] = '{64, 0, 0, 64, -64, -64};
        int ys [6] = '{0, 64, -64, 64, 64, 0};
        int ex [6] = '{0, 64, -64, 32, 96, 127};
        int ph, mg, lat, mph, mmg;
        bit ok;
        for (int k = 0; k < 6; k++) begin
            run_vec(xs[k], ys[k], ph, mg, lat, ok);
            model(xs[k], ys[k], mph, mmg);
            checks++;
            if (!ok || iabs(ph - ex[k]) > 1) begin
                failures++;
                $display("FAIL axes(%0d,%0d): phase=%0d required %0d+-1 (timeout=%0b)",
                         xs[k], ys[k], ph, ex[k], !ok);
            end
            checks++;
            if (ph != mph) begin
                failures++;
                $display("FAIL axes_model(%0d,%0d): phase=%0d required %0d", xs[k], ys[k], ph, mph);
            end
        end
    endtask

    task automatic test_zero_latency();
        int ph, mg, lat;
        bit ok;
        run_vec(0, 0, ph, mg, lat, ok);
        checks++;
        if (!ok || ph != 0 || mg != 0) begin
            failures++;
            $display("FAIL zero: phase=%0d mag=%0d required 0 0", ph, mg);
        end
        checks++;
        if (lat != ITER) begin
            failures++;
            $display("FAIL latency: out_valid %0d edges after capture, required %0d", lat, ITER);
        end
    endtask

    task automatic test_backpressure();
        int p0, t, ph, mph, mmg;
        bit bad;
        @(negedge clk);
        bus.x_in = 8'sd64; bus.y_in = 8'sd64; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 100) begin @(posedge clk); #1; t++; end
        p0 = int'(bus.phase_out);
        bus.x_in = -8'sd64; bus.y_in = 8'sd64; bus.in_valid = 1'b1;
        bad = !bus.out_valid;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (int'(bus.phase_out) != p0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL backpressure_hold: phase=%0d (was %0d) in_ready=%b out_valid=%b",
                     bus.phase_out, p0, bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_accept2: in_ready=%b required 0", bus.in_ready);
        end
        t = 0;
        while (!bus.out_valid && t < 100) begin @(posedge clk); #1; t++; end
        ph = int'(bus.phase_out);
        model(-64, 64, mph, mmg);
        checks++;
        if (t != ITER || ph != mph) begin
            failures++;
            $display("FAIL backpressure_second: phase=%0d lat=%0d required %0d lat %0d", ph, t, mph, ITER);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int ph, mg, lat, seen;
        bit ok;
        @(negedge clk);
        bus.x_in = -8'sd100; bus.y_in = 8'sd30; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin @(negedge clk); if (bus.out_valid) seen++; end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_pulse: out_valid cycles=%0d required 0", seen);
        end
        run_vec(64, 64, ph, mg, lat, ok);
        checks++;
        if (!ok || iabs(ph - 32) > 1) begin
            failures++;
            $display("FAIL reset_mid_next: phase=%0d required 32+-1", ph);
        end
    endtask

    task automatic test_extremes();
        int xs [4] = '{-128, 127, -128, -128};
        int ys [4] = '{-128, -128, 127, 0};
        int ph, mg, lat, mph, mmg;
        bit ok;
        run_vec(-128, -128, ph, mg, lat, ok);
        checks++;
        if (!ok || iabs(ph + 96) > 1) begin
            failures++;
            $display("FAIL extreme_phase: phase=%0d required -96+-1", ph);
        end
`ifdef CORDIC_MAG_OUT_EN
        checks++;
        if (iabs(mg - 298) > 2) begin
            failures++;
            $display("FAIL extreme_mag: mag=%0d required 298+-2", mg);
        end
`endif
        for (int k = 0; k < 4; k++) begin
            run_vec(xs[k], ys[k], ph, mg, lat, ok);
            model(xs[k], ys[k], mph, mmg);
            checks++;
            if (!ok || ph != mph) begin
                failures++;
                $display("FAIL extreme(%0d,%0d): phase=%0d required %0d", xs[k], ys[k], ph, mph);
            end
        end
    endtask

    task automatic test_random();
        int xv, yv, ph, mg, lat, mph, mmg, id;
        bit ok;
        for (int n = 0; n < 40; n++) begin
            xv = int'($urandom_range(255)) - 128;
            yv = int'($urandom_range(255)) - 128;
            run_vec(xv, yv, ph, mg, lat, ok);
            model(xv, yv, mph, mmg);
            checks++;
            if (!ok || ph != mph || lat != ITER) begin
                failures++;
                $display("FAIL random(%0d,%0d): phase=%0d lat=%0d required %0d lat %0d",
                         xv, yv, ph, lat, mph, ITER);
            end
`ifdef CORDIC_MAG_OUT_EN
            checks++;
            if (mg != mmg) begin
                failures++;
                $display("FAIL random_mag(%0d,%0d): mag=%0d required %0d", xv, yv, mg, mmg);
            end
`endif
            if (xv * xv + yv * yv >= 64 * 64) begin
                id = ideal_phase(xv, yv);
                checks++;
                if (iabs(ph - id) > 2) begin
                    failures++;
                    $display("FAIL random_ideal(%0d,%0d): phase=%0d required %0d+-2", xv, yv, ph, id);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int vx [3] = '{100, -50, 20};
        int vy [3] = '{-20, -90, 110};
        int cyc, acc, got, last_acc, mph, mmg;
        bit acc_now;
        cyc = 0; acc = 0; got = 0; last_acc = -1;
        bus.out_ready = 1'b1;
        bus.x_in = DATA_W'(vx[0]); bus.y_in = DATA_W'(vy[0]); bus.in_valid = 1'b1;
        while (got < 3 && cyc < 200) begin
            @(negedge clk);
            if (bus.out_valid) begin
                model(vx[got], vy[got], mph, mmg);
                checks++;
                if (int'(bus.phase_out) != mph) begin
                    failures++;
                    $display("FAIL b2b_phase[%0d]: phase=%0d required %0d", got, bus.phase_out, mph);
                end
                got++;
            end
            acc_now = bus.in_ready && bus.in_valid;
            if (acc_now) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != ITER + 2) begin
                        failures++;
                        $display("FAIL b2b_interval: %0d cycles required %0d", cyc - last_acc, ITER + 2);
                    end
                end
                last_acc = cyc;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                acc++;
                if (acc < 3) begin
                    bus.x_in = DATA_W'(vx[acc]); bus.y_in = DATA_W'(vy[acc]);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (got != 3) begin
            failures++;
            $display("FAIL b2b_count: results=%0d required 3", got);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_axes();
        test_zero_latency();
        test_backpressure();
        test_reset_mid();
        test_extremes();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cordic_atan2_phase.md
# cordic_atan2_phase

Iterative CORDIC vectoring engine that computes the signed phase atan2(y, x) of an 8-bit vector for the Jacobi rotation datapath. It produces the 2θ phase, with y = 2·a_pq and x = a_qq − a_pp. The result goes to the right-shift halving stage that derives θ. The block is a multi-cycle unit with valid/ready handshakes on both sides, so the upstream covariance logic and the downstream shifter can stall it.

## Interface
- `DATA_W`, 8: width of signed inputs `x_in` and `y_in`.
- `ITERATIONS`, 10: number of CORDIC micro-rotations. Legal range is 1..10.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: input vector is valid.
- `in_ready` output, 1 bit: block can accept a vector. High only in IDLE.
- `x_in` input, `DATA_W` bits: signed x component.
- `y_in` input, `DATA_W` bits: signed y component.
- `out_valid` output, 1 bit: `phase_out` is valid.
- `out_ready` input, 1 bit: downstream accepts the result.
- `phase_out` output, 8 bits: signed phase. LSB = π/128 rad. Range is −128..127.
- `mag_out` output, `DATA_W`+2 bits: present only with the macro (see Configuration).

## Operation
- States and transitions:
  - IDLE → ITER when `in_valid`.
  - ITER → DONE after `ITERATIONS` iterations.
  - DONE → IDLE when `out_ready`.
- Accepting a vector (`in_valid` high in IDLE):
  - Sign-extend x and y to `DATA_W`+2 bits.
  - Pre-rotate:
    - If x ≥ 0: no pre-rotation, z = 0.
    - If x < 0 and y ≥ 0: (x, y) ← (y, −x), z = +1024.
    - If x < 0 and y < 0: (x, y) ← (−y, x), z = −1024.
  - Clear the iteration counter to 0.
- Angle accumulator z: 13-bit signed, LSB = π/2048.
- Arctan ROM, atan(2^-i) in z units for i = 0..9: 512, 302, 160, 81, 41, 20, 10, 5, 3, 1.
- Iteration i, with arithmetic shifts:
  - If y ≥ 0: x += y>>>i, y −= x>>>i, z += atan_i.
  - Otherwise: x −= y>>>i, y += x>>>i, z −= atan_i.
  - Both updates use the pre-update x and y.
- Output rounding: `phase_out` = sat8((z_final + 8) >>> 4).
  - sat8 clamps to [−128, 127], so +π (128) saturates to 127.
- Zero vector: x_in = y_in = 0 sets a zero flag at capture. The result is then `phase_out` = 0 (and `mag_out` = 0).
- Back-pressure: in DONE, `phase_out` and `mag_out` hold stable until `out_ready` is high.
- `in_ready` is low in ITER and DONE. A vector presented then is not consumed.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `in_ready` = 1, `out_valid` = 0.
  - `phase_out` = 0, `mag_out` = 0.
  - x, y and z registers = 0.
- Capture happens at the edge where `in_valid && in_ready`; call it edge E0.
- Iteration k (k = 0..`ITERATIONS`−1) executes at edge E0+1+k.
- At the last iteration edge the rounded phase is registered and the state enters DONE.
  - `out_valid` is high from the cycle after edge E0+`ITERATIONS`.
- Result transfer happens at the edge where `out_valid && out_ready`.
  - The block returns to IDLE and `out_valid` drops after that edge.
- Minimum initiation interval is `ITERATIONS`+2 cycles.
- Reset asserted mid-operation: the state returns to IDLE immediately. The partial result is discarded and no `out_valid` pulse is produced.

## Configuration
- `CORDIC_MAG_OUT_EN` defined:
  - Adds port `mag_out`, unsigned.
  - Registered alongside `phase_out`: the final x register, not gain-compensated (≈1.647·|v|).
- `CORDIC_MAG_OUT_EN` undefined:
  - Port `mag_out` is absent.
  - The x datapath is unchanged; only the output register is removed.

## Test plan
- Axes, all results exact ±1 LSB:
  - (x, y) = (64, 0) → `phase_out` 0.
  - (0, 64) → 64.
  - (0, −64) → −64.
- Diagonal and negative axis, ±1 LSB:
  - (64, 64) → 32.
  - (−64, 64) → 96.
  - (−64, 0) → 127 (saturated) or 126.
- Zero and latency: vector (0, 0) → `phase_out` 0 with `out_valid` exactly `ITERATIONS`+1 cycles after the `in_valid` cycle.
- Back-pressure:
  - Hold `out_ready` low for 5 cycles in DONE → `phase_out` stable, `in_ready` low, and a second `in_valid` is not consumed.
  - Release `out_ready` → one transfer, then the second vector is accepted in IDLE.
- Reset mid-operation: assert `rst` at iteration 4 → `in_ready` = 1, `out_valid` = 0 immediately. The next vector (64, 64) still yields 32.
- Extremes: (−128, −128) → −96 ±1 with no overflow. With `CORDIC_MAG_OUT_EN`, `mag_out` ≈ 298 ±2.
